// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : In-order pipeline controller: run/drain/halt sequencing,
//                hazard stall/flush generation, operand forwarding selects
//                and saturating performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
  parameter int STAGES    = 5,
  parameter int BR_STAGE  = 3,
  parameter int REG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop_dec,
  output logic                 halted,
  output logic                 im_req,
  input  logic                 im_ack,
  input  logic                 dm_req,
  input  logic                 dm_ack,
  input  logic [REG_WIDTH-1:0] rsD,
  input  logic [REG_WIDTH-1:0] rtD,
  input  logic [REG_WIDTH-1:0] rsE,
  input  logic [REG_WIDTH-1:0] rtE,
  input  logic [REG_WIDTH-1:0] WriteRegE,
  input  logic [REG_WIDTH-1:0] WriteRegM,
  input  logic [REG_WIDTH-1:0] WriteRegW,
  input  logic                 MemReadE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 jump,
  input  logic                 branch_taken,
  output logic [STAGES-1:0]    stall,
  output logic [STAGES-1:0]    flush,
  output logic [1:0]           alu_src1,
  output logic [1:0]           alu_src2,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int                c_DW         = $clog2(STAGES) + 1;
  localparam logic [c_DW-1:0]   c_DRAIN_LOAD = c_DW'(STAGES - 2);
  localparam logic [STAGES-1:0] c_BIT0       = STAGES'(1);
  localparam logic [STAGES-1:0] c_BIT1       = STAGES'(2);
  localparam logic [STAGES-1:0] c_BIT2       = STAGES'(4);
  localparam logic [STAGES-1:0] c_LOAD_STALL = STAGES'(3);
  // Registers 1..BR_STAGE hold wrong-path instructions after a taken branch.
  localparam logic [STAGES-1:0] c_BR_MASK    = STAGES'((1 << (BR_STAGE + 1)) - 2);

  if ((STAGES < 4) || (STAGES > 8) || (BR_STAGE < 2) || (BR_STAGE > STAGES - 2)) begin : g_param_check
    $error("pipe_ctrl: STAGES or BR_STAGE out of legal range");
  end

  state_t                 r_state;
  state_t                 w_next;
  logic [c_DW-1:0]        r_drain_cnt;
  logic [c_DW-1:0]        w_drain_next;
  logic                   r_halted;
  logic [CNT_WIDTH-1:0]   r_cycle_cnt;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;

  logic                   w_dwait;
  logic                   w_load_use;
  logic                   w_im_req;
  logic                   w_active;
  logic                   w_start_acc;
  logic [STAGES-1:0]      w_hz_stall;
  logic [STAGES-1:0]      w_hz_flush;
  logic [STAGES-1:0]      w_stall;
  logic [STAGES-1:0]      w_flush;
  logic [1:0]             w_src1;
  logic [1:0]             w_src2;

  assign w_dwait     = dm_req & ~dm_ack;
  assign w_load_use  = MemReadE & ((WriteRegE == rsD) | (WriteRegE == rtD));
  assign w_im_req    = (r_state == S_RUN);
  assign w_active    = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_start_acc = ((r_state == S_IDLE) | (r_state == S_HALT)) & start;

  always_comb begin
    w_hz_stall = '0;
    w_hz_flush = '0;
    if (branch_taken) begin
      w_hz_flush = c_BR_MASK;
    end else if (w_load_use) begin
      w_hz_stall = c_LOAD_STALL;
      w_hz_flush = c_BIT2;
    end else if (jump) begin
      w_hz_flush = c_BIT1;
    end else if (w_im_req & ~im_ack) begin
      w_hz_stall = c_BIT0;
      w_hz_flush = c_BIT1;
    end
  end

  always_comb begin
    w_stall = c_BIT0;
    w_flush = c_BIT1;
    case (r_state)
      S_RUN: begin
        if (w_dwait) begin
          w_stall = '1;
          w_flush = '0;
        end else begin
          w_stall = w_hz_stall;
          w_flush = w_hz_flush;
        end
      end
      S_DRAIN: begin
        // Fetch is shut off, so IF/ID is always bubbled while older work retires.
        if (w_dwait) begin
          w_stall = '1;
          w_flush = '0;
        end else begin
          w_stall = (w_hz_stall | c_BIT0) & ~c_BIT1;
          w_flush = w_hz_flush | c_BIT1;
        end
      end
      default: begin
        w_stall = c_BIT0;
        w_flush = c_BIT1;
      end
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_drain_next = r_drain_cnt;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        if (stop_dec & ~branch_taken & ~w_dwait) begin
          w_next       = S_DRAIN;
          w_drain_next = c_DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (!w_dwait) begin
          if (r_drain_cnt <= c_DW'(1)) begin
            w_next       = S_HALT;
            w_drain_next = '0;
          end else begin
            w_drain_next = r_drain_cnt - c_DW'(1);
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= w_drain_next;
      r_halted    <= (w_next == S_HALT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (w_active) begin
      if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_stall[0] && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Forwarding selects are held at register-file source while in reset.
  always_comb begin
    w_src1 = 2'b00;
    w_src2 = 2'b00;
    if (rst) begin
      if (RegWriteM && (WriteRegM == rsE))      w_src1 = 2'b01;
      else if (RegWriteW && (WriteRegW == rsE)) w_src1 = 2'b10;
      if (RegWriteM && (WriteRegM == rtE))      w_src2 = 2'b01;
      else if (RegWriteW && (WriteRegW == rtE)) w_src2 = 2'b10;
    end
  end

  assign stall     = w_stall;
  assign flush     = w_flush;
  assign im_req    = w_im_req;
  assign halted    = r_halted;
  assign alu_src1  = w_src1;
  assign alu_src2  = w_src2;
  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed bench driving a 5-stage and a 7-stage pipe_ctrl
//                from shared stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start, stop_dec, im_ack, dm_req, dm_ack;
  logic [3:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic MemReadE, RegWriteM, RegWriteW, jump, branch_taken;

  logic        halted5, im_req5, halted7, im_req7;
  logic [4:0]  stall5, flush5;
  logic [6:0]  stall7, flush7;
  logic [1:0]  s1_5, s2_5, s1_7, s2_7;
  logic [15:0] cyc5, stc5, cyc7, stc7;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(5), .BR_STAGE(3), .REG_WIDTH(4), .CNT_WIDTH(16)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .stop_dec(stop_dec), .halted(halted5),
    .im_req(im_req5), .im_ack(im_ack), .dm_req(dm_req), .dm_ack(dm_ack),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .MemReadE(MemReadE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .jump(jump),
    .branch_taken(branch_taken), .stall(stall5), .flush(flush5),
    .alu_src1(s1_5), .alu_src2(s2_5), .cycle_cnt(cyc5), .stall_cnt(stc5)
  );

  pipe_ctrl #(.STAGES(7), .BR_STAGE(4), .REG_WIDTH(4), .CNT_WIDTH(16)) u_dut7 (
    .clk(clk), .rst(rst), .start(start), .stop_dec(stop_dec), .halted(halted7),
    .im_req(im_req7), .im_ack(im_ack), .dm_req(dm_req), .dm_ack(dm_ack),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .MemReadE(MemReadE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .jump(jump),
    .branch_taken(branch_taken), .stall(stall7), .flush(flush7),
    .alu_src1(s1_7), .alu_src2(s2_7), .cycle_cnt(cyc7), .stall_cnt(stc7)
  );

  typedef struct {
    logic       mre;
    logic [3:0] wre, rsd, rtd;
    logic       br, jmp, ia, dr, da, rwm;
    logic [3:0] wrm;
    logic       rww;
    logic [3:0] wrw, rse, rte;
    logic [4:0] st5, fl5;
    logic [6:0] st7, fl7;
    logic [1:0] s1, s2;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    start = 0; stop_dec = 0; im_ack = 1; dm_req = 0; dm_ack = 0;
    rsD = 1; rtD = 2; rsE = 1; rtE = 2; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    MemReadE = 0; RegWriteM = 0; RegWriteW = 0; jump = 0; branch_taken = 0;
  endtask

  task automatic go_run();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_imreq5"}, im_req5, 0);
    chk({tag, "_stall5"}, stall5, 5'b00001);
    chk({tag, "_flush5"}, flush5, 5'b00010);
    chk({tag, "_stall7"}, stall7, 7'b0000001);
    chk({tag, "_flush7"}, flush7, 7'b0000010);
  endtask

  // Called on the negedge just after the edge that entered DRAIN.
  task automatic run_to_halt(input int waits, input int exp5, input int exp7, input string tag);
    int h5 = -1;
    int h7 = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k <= waits) begin
        dm_req = 1; dm_ack = 0;
        #1;
        chk($sformatf("%s_w%0d_stall5", tag, k), stall5, 5'b11111);
        chk($sformatf("%s_w%0d_flush5", tag, k), flush5, 0);
        chk($sformatf("%s_w%0d_stall7", tag, k), stall7, 7'b1111111);
      end else begin
        dm_req = 0;
      end
      step();
      if (h5 < 0 && halted5) h5 = k;
      if (h7 < 0 && halted7) h7 = k;
    end
    chk({tag, "_halt5_cycles"}, h5, exp5);
    chk({tag, "_halt7_cycles"}, h7, exp7);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        mre wre rsd rtd br jmp ia dr da rwm wrm rww wrw rse rte  st5       fl5       st7         fl7         s1     s2
    vecs[0]  = '{0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b00000, 7'b0000000, 7'b0000000, 2'b00, 2'b00};
    vecs[1]  = '{1, 3, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00011, 5'b00100, 7'b0000011, 7'b0000100, 2'b00, 2'b00};
    vecs[2]  = '{1, 3, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00011, 5'b00100, 7'b0000011, 7'b0000100, 2'b00, 2'b00};
    vecs[3]  = '{1, 3, 3, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b01110, 7'b0000000, 7'b0011110, 2'b00, 2'b00};
    vecs[4]  = '{1, 3, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b00000, 7'b0000000, 7'b0000000, 2'b00, 2'b00};
    vecs[5]  = '{0, 3, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b00000, 7'b0000000, 7'b0000000, 2'b00, 2'b00};
    vecs[6]  = '{0, 0, 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b00010, 7'b0000000, 7'b0000010, 2'b00, 2'b00};
    vecs[7]  = '{1, 3, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00011, 5'b00100, 7'b0000011, 7'b0000100, 2'b00, 2'b00};
    vecs[8]  = '{0, 0, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b01110, 7'b0000000, 7'b0011110, 2'b00, 2'b00};
    vecs[9]  = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00001, 5'b00010, 7'b0000001, 7'b0000010, 2'b00, 2'b00};
    vecs[10] = '{0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b00010, 7'b0000000, 7'b0000010, 2'b00, 2'b00};
    vecs[11] = '{0, 0, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 5'b11111, 5'b00000, 7'b1111111, 7'b0000000, 2'b00, 2'b00};
    vecs[12] = '{0, 0, 1, 2, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 2, 5'b00000, 5'b00010, 7'b0000000, 7'b0000010, 2'b00, 2'b00};
    vecs[13] = '{0, 0, 1, 2, 0, 0, 1, 0, 0, 1, 5, 1, 5, 5, 7, 5'b00000, 5'b00000, 7'b0000000, 7'b0000000, 2'b01, 2'b00};
    vecs[14] = '{0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 5, 1, 5, 5, 7, 5'b00000, 5'b00000, 7'b0000000, 7'b0000000, 2'b10, 2'b00};
    vecs[15] = '{0, 0, 1, 2, 0, 0, 1, 0, 0, 1, 5, 1, 2, 2, 5, 5'b00000, 5'b00000, 7'b0000000, 7'b0000000, 2'b10, 2'b01};
    vecs[16] = '{0, 0, 1, 2, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 7'b0000000, 7'b0000000, 2'b01, 2'b01};

    // Reset with live forwarding matches and start held high.
    clr_inputs();
    rst = 0;
    RegWriteM = 1; WriteRegM = 5; rsE = 5; start = 1;
    #2;
    chk_idle_outs("rst");
    chk("rst_src1_5", s1_5, 0);
    chk("rst_src1_7", s1_7, 0);
    chk("rst_halted5", halted5, 0);
    chk("rst_cyc5", cyc5, 0);
    step();
    chk("rst_start_ignored", im_req5, 0);
    clr_inputs();
    rst = 1;
    step(); step();
    chk("post_rst_idle_imreq5", im_req5, 0);
    chk("post_rst_idle_cyc5", cyc5, 0);

    // Start, then 10 hazard-free RUN cycles.
    go_run();
    chk("run_first_cyc5", cyc5, 0);
    chk("run_imreq5", im_req5, 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("run%0d_stall5", i), stall5, 0);
      chk($sformatf("run%0d_flush7", i), flush7, 0);
      step();
    end
    chk("run10_cyc5", cyc5, 10);
    chk("run10_stc5", stc5, 0);
    chk("run10_cyc7", cyc7, 10);
    chk("run10_stc7", stc7, 0);

    // Combinational hazard/forwarding table in RUN.
    for (int i = 0; i < NV; i++) begin
      MemReadE = vecs[i].mre; WriteRegE = vecs[i].wre; rsD = vecs[i].rsd; rtD = vecs[i].rtd;
      branch_taken = vecs[i].br; jump = vecs[i].jmp; im_ack = vecs[i].ia;
      dm_req = vecs[i].dr; dm_ack = vecs[i].da; RegWriteM = vecs[i].rwm; WriteRegM = vecs[i].wrm;
      RegWriteW = vecs[i].rww; WriteRegW = vecs[i].wrw; rsE = vecs[i].rse; rtE = vecs[i].rte;
      #1;
      chk($sformatf("v%0d_stall5", i), stall5, vecs[i].st5);
      chk($sformatf("v%0d_flush5", i), flush5, vecs[i].fl5);
      chk($sformatf("v%0d_stall7", i), stall7, vecs[i].st7);
      chk($sformatf("v%0d_flush7", i), flush7, vecs[i].fl7);
      chk($sformatf("v%0d_src1_5", i), s1_5, vecs[i].s1);
      chk($sformatf("v%0d_src2_5", i), s2_5, vecs[i].s2);
      chk($sformatf("v%0d_src1_7", i), s1_7, vecs[i].s1);
      chk($sformatf("v%0d_src2_7", i), s2_7, vecs[i].s2);
      step();
    end
    clr_inputs();

    // Wrong-path STOP and STOP under data wait are both ignored.
    stop_dec = 1; branch_taken = 1;
    step();
    stop_dec = 0; branch_taken = 0;
    #1;
    chk("wrongpath_stop_run5", im_req5, 1);
    chk("wrongpath_stop_run7", im_req7, 1);
    stop_dec = 1; dm_req = 1; dm_ack = 0;
    step();
    stop_dec = 0; dm_req = 0;
    #1;
    chk("dwait_stop_run5", im_req5, 1);

    // Plain drain to HALT.
    stop_dec = 1;
    step();
    stop_dec = 0;
    #1;
    chk_idle_outs("drain1");
    run_to_halt(0, 3, 5, "drain");
    chk_idle_outs("halt");
    chk("halt_halted5", halted5, 1);
    chk("halt_halted7", halted7, 1);

    // Restart from HALT, drain with a 3-cycle data wait.
    go_run();
    chk("restart_cyc5", cyc5, 0);
    chk("restart_stc7", stc7, 0);
    chk("restart_halted5", halted5, 0);
    step(); step();
    stop_dec = 1;
    step();
    stop_dec = 0;
    run_to_halt(3, 6, 8, "wdrain");
    chk("wdrain_cyc5", cyc5, 9);
    chk("wdrain_stc5", stc5, 6);
    chk("wdrain_cyc7", cyc7, 11);
    chk("wdrain_stc7", stc7, 8);

    // Asynchronous reset in the middle of a DRAIN data wait.
    go_run();
    step();
    stop_dec = 1;
    step();
    stop_dec = 0; dm_req = 1; dm_ack = 0;
    step();
    #2;
    rst = 0;
    #1;
    chk_idle_outs("mid_rst");
    chk("mid_rst_cyc5", cyc5, 0);
    chk("mid_rst_stc5", stc5, 0);
    chk("mid_rst_cyc7", cyc7, 0);
    chk("mid_rst_halted7", halted7, 0);
    dm_req = 0;
    @(negedge clk);
    rst = 1;
    step(); step();
    chk("mid_rst_stays_idle5", im_req5, 0);
    chk("mid_rst_stays_idle7", im_req7, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
